vec_rotate: RTL and testbench
=============================

Name: vec_rotate

Overview:
Sequential Q8.8 2-D vector rotator that sits directly downstream of the combinational sine/cosine LUT.
- Accepts a vector (x, y) and an angle over a valid/ready handshake.
- Drives the angle to the LUT and captures the returned sine/cosine.
- Computes x' = x*cos - y*sin and y' = x*sin + y*cos with one shared multiplier over four cycles.
- Used by the ray/direction datapath to turn view or step vectors.

Parameters:
DATA_W, 16, width of all Q-format operands and results
FRAC_W, 8, fractional bits; product realignment shift

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request (high only in IDLE)
in_x  in  DATA_W  signed Q8.8 x component
in_y  in  DATA_W  signed Q8.8 y component
in_angle  in  DATA_W  angle; bits [10:0] are significant, 2048 = one full turn
trig_angle  out  DATA_W  registered angle driven to the sine/cosine LUT
trig_sin  in  DATA_W  signed Q8.8 sine returned combinationally for trig_angle
trig_cos  in  DATA_W  signed Q8.8 cosine returned combinationally for trig_angle
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_x  out  DATA_W  signed Q8.8 rotated x
out_y  out  DATA_W  signed Q8.8 rotated y
busy  out  1  high whenever state is not IDLE

Behaviour:
Reset
- reset_n low, asynchronous: state=IDLE.
- trig_angle, out_x, out_y and the internal regs (x, y, sin, cos, both accumulators) all clear to 0.
- out_valid=0, busy=0, in_ready=1 immediately.
- Reset mid-operation abandons the request with no output.

State machine (states: IDLE, TRIG, MUL0, MUL1, MUL2, MUL3, DONE)
- IDLE: in_ready=1. On the edge where in_valid&in_ready, capture in_x, in_y into regs and in_angle into trig_angle, then go to TRIG.
- TRIG: on the edge, register trig_sin and trig_cos (the LUT settles within this one cycle). Clear accx and accy, then go to MUL0.
- MUL0: accx += x*cos.
- MUL1: accx -= y*sin.
- MUL2: accy += x*sin.
- MUL3: accy += y*cos. Load out_x and out_y from the realigned accumulators, then go to DONE.
- DONE: out_valid=1. out_x and out_y are held stable until the edge where out_ready=1, then go to IDLE.

Handshake and timing
- in_ready is low from TRIG through DONE. There is no bypass: the next request is accepted no earlier than the cycle after the output handshake.
- out_ready may be high in advance; the result is then consumed on the first DONE edge.
- Latency: out_valid rises 6 clocks after the accepting edge. Throughput is one request per 7 clocks.
- trig_angle holds its value until the next accept. The LUT output is sampled only in TRIG.

Arithmetic
- Each product is a full signed 2*DATA_W-bit value.
- Accumulators are 2*DATA_W+2 bits signed, so the two-term sum cannot overflow.
- Result = accumulator arithmetically shifted right by FRAC_W (floor, no rounding), then reduced to DATA_W bits. Overflow handling is set by the optional feature below.
- -32768 operands are legal and follow the same rules.

Optional Feature:
Macro: VEC_ROTATE_SATURATE_EN
- Defined: a result above 0x7FFF clamps to 0x7FFF, and one below -0x8000 clamps to 0x8000.
- Undefined: the low DATA_W bits are taken (two's-complement wrap).
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package q88_pkg holds:
  - DATA_W and FRAC_W defaults
  - the state enum
  - the ANGLE_FULL_TURN=2048 constant
  - a sat_trunc function (used only under the macro)
- Natural sub-module: q88_mac, a one multiplier plus add/subtract accumulator slice with clear/add/sub controls, instanced once and sequenced by the FSM.
- The sine/cosine LUT stays outside the block and connects through trig_angle, trig_sin and trig_cos.

Test Plan:
- Identity: stub cos=0x0100, sin=0; x=0x0100, y=0x0080, angle=0 -> out_x=0x0100, out_y=0x0080. out_valid rises exactly 6 clocks after accept; trig_angle=0.
- Quarter turn: stub sin=0x0100, cos=0; x=0x0100, y=0, angle=0x0200 -> out_x=0x0000, out_y=0x0100. Negative check: x=0, y=0x0100 -> out_x=0xFF00.
- Overflow: sin=cos=0x0100; x=y=0x7F00 -> out_x=0x0000; out_y=0xFE00 without the macro, 0x7FFF with it.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0. Raise out_ready -> IDLE next cycle; a back-to-back in_valid is accepted one cycle after the output handshake.
- Reset mid-op: assert reset_n=0 asynchronously during MUL2 -> out_valid=0, trig_angle=0, in_ready=1 without waiting for a clock edge. The next request completes correctly.
- Floor truncation: cos=0x00B5, sin=0; x=0xFFFF, y=0 -> out_x=0xFFFF (floor of -181/256), out_y=0x0000.

Source files
------------

// File: rtl/q88_pkg.sv
// Shared Q8.8 definitions for the vector rotator: default widths, FSM
// state encoding, the angle full-turn constant and the saturating reducer
// used when VEC_ROTATE_SATURATE_EN is defined.
package q88_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_FRAC_W      = 8;
  localparam int DEF_ACC_W       = 2 * DEF_DATA_W + 2;
  localparam int ANGLE_FULL_TURN = 2048;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_MUL0 = 3'd2,
    ST_MUL1 = 3'd3,
    ST_MUL2 = 3'd4,
    ST_MUL3 = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // Reduce an already realigned accumulator to DEF_DATA_W bits, clamping to
  // the signed range when the upper bits are not a pure sign extension.
  function automatic logic [DEF_DATA_W-1:0] sat_trunc(input logic signed [DEF_ACC_W-1:0] v);
    logic [DEF_ACC_W-DEF_DATA_W:0] top_bits;
    top_bits = v[DEF_ACC_W-1:DEF_DATA_W-1];
    if ((top_bits == '0) || (top_bits == '1)) begin
      return v[DEF_DATA_W-1:0];
    end else if (v[DEF_ACC_W-1]) begin
      return {1'b1, {(DEF_DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DEF_DATA_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/vec_rotate_if.sv
// Request/result handshake plus sine/cosine LUT connection of vec_rotate.
// The master side is the environment (requester, consumer and LUT); the
// slave side is the rotator itself.
interface vec_rotate_if #(
  parameter int DATA_W = q88_pkg::DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic [DATA_W-1:0] in_angle;
  logic [DATA_W-1:0] trig_angle;
  logic [DATA_W-1:0] trig_sin;
  logic [DATA_W-1:0] trig_cos;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;

  modport master (
    output in_valid, in_x, in_y, in_angle, out_ready, trig_sin, trig_cos,
    input  in_ready, out_valid, out_x, out_y, trig_angle
  );

  modport slave (
    input  in_valid, in_x, in_y, in_angle, out_ready, trig_sin, trig_cos,
    output in_ready, out_valid, out_x, out_y, trig_angle
  );
endinterface

// File: rtl/q88_mac.sv
// Single signed multiplier feeding two accumulators (x and y). The FSM picks
// the accumulator with sel_i and adds or subtracts the product; clr_i zeroes
// both. acc_nxt_o exposes the post-update value of the selected accumulator
// so the final term can be folded into the result on the same edge.
module q88_mac #(
  parameter int DATA_W = q88_pkg::DEF_DATA_W,
  parameter int ACC_W  = 2 * DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic                     clr_i,
  input  logic                     add_i,
  input  logic                     sub_i,
  input  logic                     sel_i,
  output logic signed [ACC_W-1:0]  acc_x_o,
  output logic signed [ACC_W-1:0]  acc_nxt_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_sel;
  logic signed [ACC_W-1:0]    acc_x_q;
  logic signed [ACC_W-1:0]    acc_y_q;
  logic signed [ACC_W-1:0]    acc_d;

  assign prod     = a_i * b_i;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_sel  = sel_i ? acc_y_q : acc_x_q;

  // Add or subtract the product into the selected accumulator.
  always_comb begin
    acc_d = acc_sel;
    if (add_i) begin
      acc_d = acc_sel + prod_ext;
    end else if (sub_i) begin
      acc_d = acc_sel - prod_ext;
    end
  end

  // Accumulator registers; only the selected one is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
    end else if (clr_i) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
    end else if (add_i || sub_i) begin
      if (sel_i) begin
        acc_y_q <= acc_d;
      end else begin
        acc_x_q <= acc_d;
      end
    end
  end

  assign acc_x_o   = acc_x_q;
  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/vec_rotate.sv
// Sequential Q8.8 2-D vector rotator: x' = x*cos - y*sin, y' = x*sin + y*cos.
// The angle is registered onto the external sine/cosine LUT, its outputs are
// captured one cycle later, then four MAC cycles share one multiplier.
// Optional macro VEC_ROTATE_SATURATE_EN: clamp results instead of wrapping.
module vec_rotate
  import q88_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic           clk,
  input  logic           reset_n,
  vec_rotate_if.slave    bus,
  output logic           busy
);

  localparam int ACC_W = 2 * DATA_W + 2;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_q, y_q, sin_q, cos_q;
  logic        [DATA_W-1:0] trig_angle_q;
  logic        [DATA_W-1:0] out_x_q, out_y_q;

  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic                     mac_clr, mac_add, mac_sub, mac_sel;
  logic signed [ACC_W-1:0]  acc_x, acc_nxt;
  logic        [DATA_W-1:0] res_x, res_y;
  logic                     accept;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and MAC sequencing: x-terms into accx, then y-terms into accy.
  always_comb begin
    state_d = state_q;
    mac_a   = x_q;
    mac_b   = cos_q;
    mac_clr = 1'b0;
    mac_add = 1'b0;
    mac_sub = 1'b0;
    mac_sel = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_TRIG;
      ST_TRIG: begin
        mac_clr = 1'b1;
        state_d = ST_MUL0;
      end
      ST_MUL0: begin
        mac_a   = x_q;
        mac_b   = cos_q;
        mac_add = 1'b1;
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        mac_a   = y_q;
        mac_b   = sin_q;
        mac_sub = 1'b1;
        state_d = ST_MUL2;
      end
      ST_MUL2: begin
        mac_a   = x_q;
        mac_b   = sin_q;
        mac_add = 1'b1;
        mac_sel = 1'b1;
        state_d = ST_MUL3;
      end
      ST_MUL3: begin
        mac_a   = y_q;
        mac_b   = cos_q;
        mac_add = 1'b1;
        mac_sel = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  q88_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_i       (mac_a),
    .b_i       (mac_b),
    .clr_i     (mac_clr),
    .add_i     (mac_add),
    .sub_i     (mac_sub),
    .sel_i     (mac_sel),
    .acc_x_o   (acc_x),
    .acc_nxt_o (acc_nxt)
  );

  // Realign by FRAC_W (floor) and reduce to DATA_W bits. In MUL3 accx is
  // final and acc_nxt already holds accy including the y*cos term.
`ifdef VEC_ROTATE_SATURATE_EN
  assign res_x = sat_trunc(acc_x >>> FRAC_W);
  assign res_y = sat_trunc(acc_nxt >>> FRAC_W);
`else
  logic unused_acc_bits;
  assign res_x = acc_x[FRAC_W +: DATA_W];
  assign res_y = acc_nxt[FRAC_W +: DATA_W];
  assign unused_acc_bits = ^{acc_x[ACC_W-1:FRAC_W+DATA_W], acc_x[FRAC_W-1:0],
                             acc_nxt[ACC_W-1:FRAC_W+DATA_W], acc_nxt[FRAC_W-1:0]};
`endif

  // Operand capture, LUT sampling and result load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      sin_q        <= '0;
      cos_q        <= '0;
      trig_angle_q <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      if (accept) begin
        x_q          <= bus.in_x;
        y_q          <= bus.in_y;
        trig_angle_q <= bus.in_angle;
      end
      if (state_q == ST_TRIG) begin
        sin_q <= bus.trig_sin;
        cos_q <= bus.trig_cos;
      end
      if (state_q == ST_MUL3) begin
        out_x_q <= res_x;
        out_y_q <= res_y;
      end
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.trig_angle = trig_angle_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vec_rotate.sv
// Directed testbench for vec_rotate with a constant sine/cosine LUT stub.
// Latency is counted in rising edges from the accepting edge until
// out_valid is observed; the FSM (TRIG, MUL0..MUL3) gives 5 edges, i.e.
// the result is present in the 6th clock counting the accept cycle.
module tb_vec_rotate;
  import q88_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy;
  logic [15:0] stub_sin, stub_cos;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat;

  vec_rotate_if #(.DATA_W(16)) bus ();

  assign bus.trig_sin = stub_sin;
  assign bus.trig_cos = stub_cos;

  vec_rotate #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a request and return just after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] ang);
    int n;
    @(negedge clk);
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_angle = ang;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Count rising edges until out_valid is seen (bounded).
  task automatic wait_out(output int l);
    l = 0;
    while (l < 20) begin
      @(posedge clk);
      l++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  // Full transaction with out_ready already high.
  task automatic xform(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ang, input logic [15:0] ex, input logic [15:0] ey);
    int l;
    send(x, y, ang);
    wait_out(l);
    check({tag, "_lat"}, 32'(l), 32'(5));
    check({tag, "_x"}, 32'(bus.out_x), 32'(ex));
    check({tag, "_y"}, 32'(bus.out_y), 32'(ey));
    check({tag, "_angle"}, 32'(bus.trig_angle), 32'(ang));
    $display("txn %s: x=%h y=%h ang=%h sin=%h cos=%h -> out_x=%h out_y=%h lat=%0d",
             tag, x, y, ang, stub_sin, stub_cos, bus.out_x, bus.out_y, l);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stable;
    logic [15:0] quarter;
    quarter       = 16'(ANGLE_FULL_TURN / 4);
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_angle  = '0;
    bus.out_ready = 1'b1;
    stub_sin      = '0;
    stub_cos      = 16'h0100;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_angle", 32'(bus.trig_angle), 32'(0));
    check("rst_out_x", 32'(bus.out_x), 32'(0));
    check("rst_out_y", 32'(bus.out_y), 32'(0));
    reset_n = 1'b1;

    // Identity rotation.
    stub_sin = 16'h0000; stub_cos = 16'h0100;
    xform("identity", 16'h0100, 16'h0080, 16'h0000, 16'h0100, 16'h0080);
    check("identity_idle_after", 32'(bus.in_ready), 32'(1));

    // Quarter turn, positive and negative result.
    stub_sin = 16'h0100; stub_cos = 16'h0000;
    xform("quarter_a", 16'h0100, 16'h0000, quarter, 16'h0000, 16'h0100);
    xform("quarter_b", 16'h0000, 16'h0100, quarter, 16'hFF00, 16'h0000);

    // Overflow: y' = 254.0 does not fit Q8.8.
    stub_sin = 16'h0100; stub_cos = 16'h0100;
`ifdef VEC_ROTATE_SATURATE_EN
    xform("overflow", 16'h7F00, 16'h7F00, 16'h0100, 16'h0000, 16'h7FFF);
`else
    xform("overflow", 16'h7F00, 16'h7F00, 16'h0100, 16'h0000, 16'hFE00);
`endif

    // Most negative operands everywhere: y' = 32768.0.
    stub_sin = 16'h8000; stub_cos = 16'h8000;
`ifdef VEC_ROTATE_SATURATE_EN
    xform("minval", 16'h8000, 16'h8000, 16'h0300, 16'h0000, 16'h7FFF);
`else
    xform("minval", 16'h8000, 16'h8000, 16'h0300, 16'h0000, 16'h0000);
`endif

    // Floor truncation of -181/256.
    stub_sin = 16'h0000; stub_cos = 16'h00B5;
    xform("floor", 16'hFFFF, 16'h0000, 16'h0040, 16'hFFFF, 16'h0000);

    // Backpressure in DONE, then back-to-back request.
    stub_sin = 16'h0000; stub_cos = 16'h0100;
    bus.out_ready = 1'b0;
    send(16'h0300, 16'hFD00, 16'h0010);
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'(5));
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_x == 16'h0300 && bus.out_y == 16'hFD00 && !bus.in_ready)
        stable++;
    end
    check("bp_stable_cycles", 32'(stable), 32'(10));
    $display("txn backpressure: out_x=%h out_y=%h held %0d cycles", bus.out_x, bus.out_y, stable);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_x      = 16'h0040;
    bus.in_y      = 16'h0020;
    bus.in_angle  = 16'h0020;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
    check("bp_release_out_valid", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("b2b_busy", 32'(busy), 32'(1));
    wait_out(lat);
    check("b2b_lat", 32'(lat), 32'(5));
    check("b2b_x", 32'(bus.out_x), 32'(16'h0040));
    check("b2b_y", 32'(bus.out_y), 32'(16'h0020));
    check("b2b_angle", 32'(bus.trig_angle), 32'(16'h0020));
    $display("txn back_to_back: out_x=%h out_y=%h lat=%0d", bus.out_x, bus.out_y, lat);
    @(posedge clk);
    #1;

    // Asynchronous reset while in MUL2.
    stub_sin = 16'h0100; stub_cos = 16'h0000;
    send(16'h0100, 16'h0200, 16'h0123);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'(0));
    check("arst_angle", 32'(bus.trig_angle), 32'(0));
    check("arst_in_ready", 32'(bus.in_ready), 32'(1));
    check("arst_busy", 32'(busy), 32'(0));
    $display("txn reset_mid_op: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    @(negedge clk);
    reset_n = 1'b1;
    xform("after_reset", 16'h0100, 16'h0200, 16'h0123, 16'hFE00, 16'h0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
